sar_scan_ctrl: RTL and testbench

SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

---
 rtl/sar_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_sar_scan_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl
// -------------
// Multi-channel successive-approximation scan controller. On an accepted
// start it walks the enabled channels of ch_mask from lowest to highest. For
// each channel it runs a sample phase, then a WIDTH-step binary search
// against the selected comparator, and then a one-cycle store of the result.
// In continuous mode the mask is sampled again when each scan completes, and
// the next scan begins at once unless the new mask is empty.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      scan request; only looked at in IDLE
//   abort      cancel the running scan; looked at in every state
//   mode       0 = single scan, 1 = continuous; captured with start
//   ch_mask    channel enable mask; captured with start and at each wrap
//   cmp_sel    0 = cmp_int, 1 = cmp_ext; captured with start
//   cmp_int    internal comparator, 1 means Vin >= DAC
//   cmp_ext    external comparator, same polarity
//   dac_code   DAC trial code
//   sample     high during the sample phase
//   ch_sel     analog mux select
//   busy       high whenever the FSM is not in IDLE
//   res_valid  one-cycle strobe qualifying res_data / res_ch
//   res_data   conversion result, held between strobes
//   res_ch     channel of res_data, held between strobes
//   eos        end-of-scan strobe, coincident with the last res_valid
//   state_dbg  current FSM state (0 IDLE, 1 SAMPLE, 2 CONV, 3 STORE)
//
// Handshake: there is no back-pressure. start is a level request that is
// consumed by the first edge that sees it in IDLE with a nonzero mask and no
// abort. res_valid/eos are single-cycle strobes that the consumer must take
// in the cycle they appear, and abort wins over every other transition.

module sar_scan_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 2,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp_sel,
  input  logic             cmp_int,
  input  logic             cmp_ext,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic [CW-1:0]    ch_sel,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [CW-1:0]    res_ch,
  output logic             eos,
  output logic [1:0]       state_dbg
);

  // Bit-position counter width; WIDTH >= 4 keeps this at 2 or more.
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CONV   = 2'd2,
    S_STORE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Values captured when a scan is accepted.
  logic             mode_q;
  logic             cmp_sel_q;
  logic [NCH-1:0]   mask_q;

  // Phase counters and the decided bits of the running conversion.
  logic [3:0]       samp_cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] code_q;

  // Index of the lowest set bit of m. Scanning from the top down lets the
  // lowest hit overwrite the others.
  function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest set bit of m strictly above cur.
  function automatic logic [CW:0] next_set(input logic [NCH-1:0] m,
                                           input logic [CW-1:0]  cur);
    logic          found;
    logic [CW-1:0] idx;
    found = 1'b0;
    idx   = cur;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = CW'(i);
      end
    end
    return {found, idx};
  endfunction

  logic             cmp_bit;
  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] trial_code;
  logic [CW:0]      nxt_info;
  logic             has_next;
  logic [CW-1:0]    next_ch;
  logic             accept;
  logic             samp_done;
  logic             conv_done;
  logic             wrap_ok;

  // The comparator choice is the one captured at start, so toggling cmp_sel
  // during a scan has no effect.
  assign cmp_bit    = cmp_sel_q ? cmp_ext : cmp_int;
  assign trial_bit  = WIDTH'(1) << bit_idx;
  assign trial_code = code_q | trial_bit;

  assign nxt_info   = next_set(mask_q, ch_sel);
  assign has_next   = nxt_info[CW];
  assign next_ch    = nxt_info[CW-1:0];

  // abort outranks start, even in IDLE.
  assign accept     = start && (|ch_mask) && !abort;
  assign samp_done  = (samp_cnt == 4'(SAMPLE_CYC - 1));
  assign conv_done  = (bit_idx == '0);
  // Continuous wrap uses the live mask, which is captured on this same edge.
  assign wrap_ok    = mode_q && (|ch_mask);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)          state_nxt = S_IDLE;
        else if (samp_done) state_nxt = S_CONV;
      end
      S_CONV: begin
        if (abort)          state_nxt = S_IDLE;
        else if (conv_done) state_nxt = S_STORE;
      end
      S_STORE: begin
        if (abort)                    state_nxt = S_IDLE;
        else if (has_next || wrap_ok) state_nxt = S_SAMPLE;
        else                          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    dac_code  = '0;
    sample    = 1'b0;
    res_valid = 1'b0;
    eos       = 1'b0;
    case (state)
      S_SAMPLE: begin
        sample   = 1'b1;
        dac_code = {1'b1, {(WIDTH-1){1'b0}}};
      end
      S_CONV: begin
        dac_code = trial_code;
      end
      S_STORE: begin
        res_valid = 1'b1;
        eos       = !has_next;
      end
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      cmp_sel_q <= 1'b0;
      mask_q    <= '0;
      ch_sel    <= '0;
      samp_cnt  <= '0;
      bit_idx   <= '0;
      code_q    <= '0;
      res_data  <= '0;
      res_ch    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            cmp_sel_q <= cmp_sel;
            mask_q    <= ch_mask;
            ch_sel    <= lowest_set(ch_mask);
            samp_cnt  <= '0;
          end
        end
        S_SAMPLE: begin
          // Prime the search so the first CONV cycle tries the MSB alone.
          samp_cnt <= samp_cnt + 4'd1;
          code_q   <= '0;
          bit_idx  <= BW'(WIDTH - 1);
        end
        S_CONV: begin
          if (!abort) begin
            if (cmp_bit) code_q <= trial_code;
            bit_idx <= bit_idx - BW'(1);
            // The final decision is folded straight into the result so that
            // res_data is already correct in the STORE cycle.
            if (conv_done) begin
              res_data <= cmp_bit ? trial_code : code_q;
              res_ch   <= ch_sel;
            end
          end
        end
        S_STORE: begin
          if (!abort) begin
            samp_cnt <= '0;
            if (has_next) begin
              ch_sel <= next_ch;
            end else if (mode_q) begin
              mask_q <= ch_mask;
              if (|ch_mask) ch_sel <= lowest_set(ch_mask);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Bench for sar_scan_ctrl at WIDTH=8, NCH=4, SAMPLE_CYC=2. The comparator is
// an ideal model cmp = (vin[ch_sel] >= dac_code), so every conversion must
// reproduce vin exactly. A reference model describes each scan as a list of
// channels and a position inside an 11-cycle channel period; a compare
// process checks every output on every falling edge, and the directed
// scenarios add hand-computed literal checks at fixed cycle offsets.

module tb_sar_scan_ctrl;

  localparam int W = 8;
  localparam int S = 2;
  localparam int P = S + W + 1;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT connections.
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] ch_mask = 4'b0;
  logic       cmp_sel = 1'b0;
  logic       cmp_int;
  logic       cmp_ext;
  logic [7:0] dac_code;
  logic       sample;
  logic [1:0] ch_sel;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_ch;
  logic       eos;
  logic [1:0] state_dbg;

  sar_scan_ctrl #(.WIDTH(8), .NCH(4), .SAMPLE_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .ch_mask   (ch_mask),
    .cmp_sel   (cmp_sel),
    .cmp_int   (cmp_int),
    .cmp_ext   (cmp_ext),
    .dac_code  (dac_code),
    .sample    (sample),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ch    (res_ch),
    .eos       (eos),
    .state_dbg (state_dbg)
  );

  // Analog inputs and comparator model.
  logic [7:0] vin [4];
  logic       ext_test = 1'b0;
  logic       model_cmp;

  initial begin
    for (int i = 0; i < 4; i++) vin[i] = 8'h00;
  end

  always_comb begin
    model_cmp = (vin[ch_sel] >= dac_code);
    cmp_int   = ext_test ? 1'b0 : model_cmp;
    cmp_ext   = ext_test ? model_cmp : 1'b0;
  end

  // Scoreboard counters.
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a scan is a list of channels; each channel occupies P
  // cycles, S of sampling, W of bit trials, then one cycle of result.
  bit m_busy     = 1'b0;
  bit m_mode     = 1'b0;
  int m_k        = 0;
  int m_idx      = 0;
  int m_chs[$];
  int m_last_ch  = 0;
  int m_res_data = 0;
  int m_res_ch   = 0;

  // Code presented in trial j (0 = MSB): the upper j bits of v already
  // decided, then the bit under test set, then zeros.
  function automatic logic [7:0] exp_trial(input logic [7:0] v, input int j);
    int keep;
    keep = (int'(v) >> (W - j)) << (W - j);
    return 8'(keep | (1 << (W - 1 - j)));
  endfunction

  task automatic build_list(input logic [3:0] m);
    m_chs.delete();
    for (int i = 0; i < 4; i++) if (m[i]) m_chs.push_back(i);
  endtask

  task automatic model_step();
    int ch;
    if (rst) begin
      m_busy     = 1'b0;
      m_mode     = 1'b0;
      m_last_ch  = 0;
      m_res_data = 0;
      m_res_ch   = 0;
    end else if (!m_busy) begin
      if (start && (ch_mask != 4'b0) && !abort) begin
        build_list(ch_mask);
        m_busy = 1'b1;
        m_mode = mode;
        m_k    = 0;
        m_idx  = 0;
      end
    end else begin
      ch = m_chs[m_idx];
      if (abort) begin
        m_busy    = 1'b0;
        m_last_ch = ch;
      end else begin
        if (m_k == S + W - 1) begin
          m_res_data = int'(vin[ch]);
          m_res_ch   = ch;
        end
        if (m_k == P - 1) begin
          m_k = 0;
          m_idx++;
          if (m_idx == m_chs.size()) begin
            if (m_mode && (ch_mask != 4'b0)) begin
              build_list(ch_mask);
              m_idx = 0;
            end else begin
              m_busy    = 1'b0;
              m_last_ch = ch;
            end
          end
        end else begin
          m_k++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  task automatic compare_outputs();
    logic [7:0] e_dac;
    logic       e_sample;
    logic       e_rv;
    logic       e_eos;
    int         e_ch;
    int         ch;
    e_dac    = 8'h00;
    e_sample = 1'b0;
    e_rv     = 1'b0;
    e_eos    = 1'b0;
    e_ch     = m_last_ch;
    if (m_busy) begin
      ch       = m_chs[m_idx];
      e_ch     = ch;
      e_sample = (m_k < S);
      if (m_k < S)          e_dac = 8'h80;
      else if (m_k < S + W) e_dac = exp_trial(vin[ch], m_k - S);
      e_rv  = (m_k == S + W);
      e_eos = e_rv && (m_idx == m_chs.size() - 1);
    end
    chk("busy",      32'(busy),      32'(m_busy));
    chk("sample",    32'(sample),    32'(e_sample));
    chk("dac_code",  32'(dac_code),  32'(e_dac));
    chk("ch_sel",    32'(ch_sel),    32'(e_ch));
    chk("res_valid", 32'(res_valid), 32'(e_rv));
    chk("eos",       32'(eos),       32'(e_eos));
    chk("res_data",  32'(res_data),  32'(m_res_data));
    chk("res_ch",    32'(res_ch),    32'(m_res_ch));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compare_outputs();
    end
  end

  // Driver tasks. Inputs change 1 time unit after a falling edge, so they are
  // stable at the following rising edge.
  task automatic goto_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_start(input logic md, input logic [3:0] mk, input logic sel,
                          output int t0);
    @(negedge clk);
    #1;
    mode    = md;
    ch_mask = mk;
    cmp_sel = sel;
    start   = 1'b1;
    @(negedge clk);
    t0 = cyc - 1;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  // Directed scenarios.
  initial begin
    int t0;
    logic [7:0] seq_ff [8];
    logic [7:0] seq_00 [8];
    seq_ff = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    seq_00 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // Reset state.
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_dac",       32'(dac_code),  32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_state",     32'(state_dbg), 32'd0);
    #1;
    rst = 1'b0;

    // Single scan over channels 0 and 2.
    vin[0] = 8'hA5;
    vin[2] = 8'h3C;
    do_start(1'b0, 4'b0101, 1'b0, t0);
    goto_cycle(t0 + 1);
    chk("single_sample_first", 32'(sample), 32'd1);
    goto_cycle(t0 + 2);
    chk("single_sample_last", 32'(sample), 32'd1);
    goto_cycle(t0 + 3);
    chk("single_conv_sample", 32'(sample), 32'd0);
    chk("single_conv_msb", 32'(dac_code), 32'h80);
    goto_cycle(t0 + 11);
    chk("single_rv0",   32'(res_valid), 32'd1);
    chk("single_data0", 32'(res_data),  32'hA5);
    chk("single_ch0",   32'(res_ch),    32'd0);
    chk("single_eos0",  32'(eos),       32'd0);
    goto_cycle(t0 + 22);
    chk("single_rv2",   32'(res_valid), 32'd1);
    chk("single_data2", 32'(res_data),  32'h3C);
    chk("single_ch2",   32'(res_ch),    32'd2);
    chk("single_eos2",  32'(eos),       32'd1);
    goto_cycle(t0 + 23);
    chk("single_idle",  32'(busy),      32'd0);
    wait_idle(40);

    // Extremes: full-scale and zero input.
    vin[0] = 8'hFF;
    do_start(1'b0, 4'b0001, 1'b0, t0);
    for (int j = 0; j < 8; j++) begin
      goto_cycle(t0 + 3 + j);
      chk("trial_ff", 32'(dac_code), 32'(seq_ff[j]));
    end
    goto_cycle(t0 + 11);
    chk("result_ff", 32'(res_data), 32'hFF);
    wait_idle(40);

    vin[0] = 8'h00;
    do_start(1'b0, 4'b0001, 1'b0, t0);
    for (int j = 0; j < 8; j++) begin
      goto_cycle(t0 + 3 + j);
      chk("trial_00", 32'(dac_code), 32'(seq_00[j]));
    end
    goto_cycle(t0 + 11);
    chk("result_00", 32'(res_data), 32'h00);
    chk("result_00_rv", 32'(res_valid), 32'd1);
    wait_idle(40);

    // Continuous scan of channel 3; the mask is cleared during the fourth scan.
    vin[3] = 8'h5A;
    do_start(1'b1, 4'b1000, 1'b0, t0);
    for (int k = 1; k <= 3; k++) begin
      goto_cycle(t0 + 11 * k);
      chk("cont_rv",   32'(res_valid), 32'd1);
      chk("cont_eos",  32'(eos),       32'd1);
      chk("cont_data", 32'(res_data),  32'h5A);
      chk("cont_ch",   32'(res_ch),    32'd3);
    end
    goto_cycle(t0 + 38);
    #1;
    ch_mask = 4'b0000;
    goto_cycle(t0 + 44);
    chk("cont_last_eos", 32'(eos), 32'd1);
    goto_cycle(t0 + 45);
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_ch",   32'(ch_sel), 32'd3);
    mode = 1'b0;
    wait_idle(40);

    // Abort in the fourth CONV cycle.
    vin[0] = 8'h33;
    do_start(1'b0, 4'b0001, 1'b0, t0);
    goto_cycle(t0 + 6);
    #1;
    abort = 1'b1;
    goto_cycle(t0 + 7);
    chk("abort_busy", 32'(busy),     32'd0);
    chk("abort_dac",  32'(dac_code), 32'd0);
    chk("abort_data", 32'(res_data), 32'h5A);
    chk("abort_ch",   32'(res_ch),   32'd3);
    #1;
    abort = 1'b0;
    goto_cycle(t0 + 11);
    chk("abort_no_rv", 32'(res_valid), 32'd0);
    wait_idle(40);

    // Start with an empty mask is ignored.
    do_start(1'b0, 4'b0000, 1'b0, t0);
    goto_cycle(t0 + 1);
    chk("mask0_busy1", 32'(busy), 32'd0);
    goto_cycle(t0 + 2);
    chk("mask0_busy2", 32'(busy), 32'd0);

    // Start while busy, with different mode and mask, is ignored.
    vin[0] = 8'h77;
    do_start(1'b0, 4'b0001, 1'b0, t0);
    goto_cycle(t0 + 2);
    #1;
    start   = 1'b1;
    mode    = 1'b1;
    ch_mask = 4'b1111;
    goto_cycle(t0 + 3);
    #1;
    start   = 1'b0;
    goto_cycle(t0 + 11);
    chk("busy_start_data", 32'(res_data), 32'h77);
    chk("busy_start_eos",  32'(eos),      32'd1);
    goto_cycle(t0 + 12);
    chk("busy_start_idle", 32'(busy), 32'd0);
    mode    = 1'b0;
    ch_mask = 4'b0000;
    wait_idle(40);

    // External comparator; cmp_sel toggled mid-scan.
    ext_test = 1'b1;
    vin[1] = 8'h96;
    vin[2] = 8'h01;
    do_start(1'b0, 4'b0110, 1'b1, t0);
    goto_cycle(t0 + 5);
    #1;
    cmp_sel = 1'b0;
    goto_cycle(t0 + 11);
    chk("ext_data1", 32'(res_data), 32'h96);
    chk("ext_ch1",   32'(res_ch),   32'd1);
    goto_cycle(t0 + 22);
    chk("ext_data2", 32'(res_data), 32'h01);
    chk("ext_ch2",   32'(res_ch),   32'd2);
    chk("ext_eos2",  32'(eos),      32'd1);
    wait_idle(40);
    ext_test = 1'b0;

    // Reset during SAMPLE.
    vin[0] = 8'h44;
    do_start(1'b0, 4'b0011, 1'b0, t0);
    goto_cycle(t0 + 1);
    #1;
    rst = 1'b1;
    goto_cycle(t0 + 2);
    chk("rst_mid_busy",   32'(busy),      32'd0);
    chk("rst_mid_sample", 32'(sample),    32'd0);
    chk("rst_mid_dac",    32'(dac_code),  32'd0);
    chk("rst_mid_ch",     32'(ch_sel),    32'd0);
    chk("rst_mid_data",   32'(res_data),  32'd0);
    chk("rst_mid_rch",    32'(res_ch),    32'd0);
    chk("rst_mid_rv",     32'(res_valid), 32'd0);
    chk("rst_mid_eos",    32'(eos),       32'd0);
    #1;
    rst = 1'b0;
    repeat (14) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
